// File: rtl/axis_stream_arbiter_pkg.sv
// Shared types for the two-port AXI-Stream packet arbiter.
// State encoding and source tags used by the FSM and the output stream.
package memctl_pkg;

   typedef enum logic [1:0] {
      IDLE,
      XFER_S01,
      XFER_S02
   } arb_state_t;

   localparam logic SRC_S01 = 1'b0;
   localparam logic SRC_S02 = 1'b1;

endpackage

// File: rtl/axis_stream_arbiter_if.sv
// AXI-Stream bundle: data, strobes, valid/ready handshake and tlast.
// Source ports use slave, the merged output uses master.
interface axis_stream_arbiter_if #(
   parameter int DATA_WIDTH = 32
);
   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] tdata;
   logic [STRB_WIDTH-1:0] tstrb;
   logic                  tvalid;
   logic                  tlast;
   logic                  tready;

   modport master (
      output tdata,
      output tstrb,
      output tvalid,
      output tlast,
      input  tready
   );

   modport slave (
      input  tdata,
      input  tstrb,
      input  tvalid,
      input  tlast,
      output tready
   );

endinterface

// File: rtl/axis_stream_arbiter_reg_slice.sv
// One-entry output register for the merged stream.
// Accepts a new beat whenever empty or draining in the same cycle.
module axis_reg_slice #(
   parameter int DATA_WIDTH = 32,
   parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic [STRB_WIDTH-1:0] in_strb,
   input  logic                  in_last,
   input  logic                  in_id,
   output logic                  in_ready,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [STRB_WIDTH-1:0] out_strb,
   output logic                  out_last,
   output logic                  out_id,
   input  logic                  out_ready
);

   assign in_ready = !out_valid || out_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_strb  <= '0;
         out_last  <= 1'b0;
         out_id    <= 1'b0;
      end else if (in_valid && in_ready) begin
         out_valid <= 1'b1;
         out_data  <= in_data;
         out_strb  <= in_strb;
         out_last  <= in_last;
         out_id    <= in_id;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/axis_stream_arbiter.sv
// Two-port packet round-robin AXI-Stream arbiter with registered output.
// Optional per-port packet counters under AXIS_ARB_PKT_COUNT_EN.
module axis_stream_arbiter
   import memctl_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                   axis_aclk,
   input  logic                   axis_aresetn,
   axis_stream_arbiter_if.slave   s01_axis,
   axis_stream_arbiter_if.slave   s02_axis,
   axis_stream_arbiter_if.master  m01_axis,
   output logic                   m01_axis_tid
`ifdef AXIS_ARB_PKT_COUNT_EN
   ,
   output logic [15:0]            pkt_cnt_s01,
   output logic [15:0]            pkt_cnt_s02
`endif
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   arb_state_t state_q, state_d;
   logic       last_grant_q, last_grant_d;

   logic                  sel_valid;
   logic [DATA_WIDTH-1:0] sel_data;
   logic [STRB_WIDTH-1:0] sel_strb;
   logic                  sel_last;
   logic                  sel_id;
   logic                  slice_ready;
   logic                  acc_s01;
   logic                  acc_s02;

   assign s01_axis.tready = (state_q == XFER_S01) && slice_ready;
   assign s02_axis.tready = (state_q == XFER_S02) && slice_ready;

   assign acc_s01 = s01_axis.tvalid && s01_axis.tready;
   assign acc_s02 = s02_axis.tvalid && s02_axis.tready;

   always_ff @(posedge axis_aclk) begin
      if (!axis_aresetn) begin
         state_q      <= IDLE;
         last_grant_q <= SRC_S02;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
      end
   end

   // Contention goes to whichever port did not win last time
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      unique case (state_q)
         IDLE: begin
            if (s01_axis.tvalid && s02_axis.tvalid) begin
               if (last_grant_q == SRC_S02) begin
                  state_d      = XFER_S01;
                  last_grant_d = SRC_S01;
               end else begin
                  state_d      = XFER_S02;
                  last_grant_d = SRC_S02;
               end
            end else if (s01_axis.tvalid) begin
               state_d      = XFER_S01;
               last_grant_d = SRC_S01;
            end else if (s02_axis.tvalid) begin
               state_d      = XFER_S02;
               last_grant_d = SRC_S02;
            end
         end
         XFER_S01: begin
            if (acc_s01 && s01_axis.tlast)
               state_d = IDLE;
         end
         XFER_S02: begin
            if (acc_s02 && s02_axis.tlast)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      sel_valid = 1'b0;
      sel_data  = s01_axis.tdata;
      sel_strb  = s01_axis.tstrb;
      sel_last  = s01_axis.tlast;
      sel_id    = SRC_S01;
      unique case (1'b1)
         (state_q == XFER_S01): begin
            sel_valid = s01_axis.tvalid;
         end
         (state_q == XFER_S02): begin
            sel_valid = s02_axis.tvalid;
            sel_data  = s02_axis.tdata;
            sel_strb  = s02_axis.tstrb;
            sel_last  = s02_axis.tlast;
            sel_id    = SRC_S02;
         end
         default: ;
      endcase
   end

   axis_reg_slice #(
      .DATA_WIDTH (DATA_WIDTH),
      .STRB_WIDTH (STRB_WIDTH)
   ) u_slice (
      .clk       (axis_aclk),
      .rst_n     (axis_aresetn),
      .in_valid  (sel_valid),
      .in_data   (sel_data),
      .in_strb   (sel_strb),
      .in_last   (sel_last),
      .in_id     (sel_id),
      .in_ready  (slice_ready),
      .out_valid (m01_axis.tvalid),
      .out_data  (m01_axis.tdata),
      .out_strb  (m01_axis.tstrb),
      .out_last  (m01_axis.tlast),
      .out_id    (m01_axis_tid),
      .out_ready (m01_axis.tready)
   );

`ifdef AXIS_ARB_PKT_COUNT_EN
   logic [15:0] cnt_s01_q;
   logic [15:0] cnt_s02_q;

   always_ff @(posedge axis_aclk) begin
      if (!axis_aresetn) begin
         cnt_s01_q <= '0;
         cnt_s02_q <= '0;
      end else begin
         if (acc_s01 && s01_axis.tlast)
            cnt_s01_q <= cnt_s01_q + 16'd1;
         if (acc_s02 && s02_axis.tlast)
            cnt_s02_q <= cnt_s02_q + 16'd1;
      end
   end

   assign pkt_cnt_s01 = cnt_s01_q;
   assign pkt_cnt_s02 = cnt_s02_q;
`endif

endmodule

// File: tb/tb_axis_stream_arbiter.sv
// Scoreboard bench for axis_stream_arbiter: arbitration order,
// latency, stall hold, mid-packet reset and optional packet counters.
module tb_axis_stream_arbiter;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic m_tid;
   int   cyc = 0;
   int   nvec = 0;
   int   nerr = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   axis_stream_arbiter_if #(.DATA_WIDTH(32)) s01 ();
   axis_stream_arbiter_if #(.DATA_WIDTH(32)) s02 ();
   axis_stream_arbiter_if #(.DATA_WIDTH(32)) m01 ();

`ifdef AXIS_ARB_PKT_COUNT_EN
   logic [15:0] cnt1, cnt2;
`endif

   axis_stream_arbiter #(.DATA_WIDTH(32)) dut (
      .axis_aclk    (clk),
      .axis_aresetn (rst_n),
      .s01_axis     (s01),
      .s02_axis     (s02),
      .m01_axis     (m01),
      .m01_axis_tid (m_tid)
`ifdef AXIS_ARB_PKT_COUNT_EN
      ,
      .pkt_cnt_s01  (cnt1),
      .pkt_cnt_s02  (cnt2)
`endif
   );

   typedef struct {
      logic [31:0] d;
      logic [3:0]  s;
      logic        l;
      logic        id;
      int          acc;
   } exp_t;

   exp_t sb[$];
   logic src_log[$];

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Monitor: runs mid-low-phase, after the bench has driven inputs
   logic        stall_p = 1'b0;
   logic [31:0] hold_d;
   logic        hold_l;
   always @(negedge clk) begin
      exp_t e;
      #2;
      if (stall_p) begin
         chk("hold_data", m01.tdata, hold_d);
         chk("hold_last", m01.tlast, hold_l);
      end
      if (m01.tvalid === 1'b1 && !m01.tready)
         chk("stall_rdy", s01.tready | s02.tready, 0);
      if (m01.tvalid === 1'b1 && !stall_p && sb.size() > 0)
         chk("latency", cyc, sb[0].acc);
      if (m01.tvalid === 1'b1 && m01.tready) begin
         if (sb.size() == 0) begin
            chk("sb_underflow", 0, 1);
         end else begin
            e = sb.pop_front();
            chk("data", m01.tdata, e.d);
            chk("strb", m01.tstrb, e.s);
            chk("last", m01.tlast, e.l);
            chk("tid", m_tid, e.id);
            if (m01.tlast)
               src_log.push_back(m_tid);
         end
      end
      stall_p = (m01.tvalid === 1'b1) && !m01.tready;
      hold_d  = m01.tdata;
      hold_l  = m01.tlast;
   end

   task automatic drive(input bit port, input logic [31:0] d,
                        input bit last);
      if (!port) begin
         s01.tvalid = 1'b1;
         s01.tdata  = d;
         s01.tstrb  = d[3:0];
         s01.tlast  = last;
      end else begin
         s02.tvalid = 1'b1;
         s02.tdata  = d;
         s02.tstrb  = d[3:0];
         s02.tlast  = last;
      end
   endtask

   // Called at a negedge; returns at the negedge after acceptance
   task automatic send_beat(input bit port, input logic [31:0] d,
                            input bit last);
      logic rdy;
      drive(port, d, last);
      for (int t = 0; t < 200; t++) begin
         #1;
         rdy = port ? s02.tready : s01.tready;
         if (rdy) begin
            sb.push_back('{d, d[3:0], last, port, cyc + 1});
            @(negedge clk);
            return;
         end
         @(negedge clk);
      end
      chk("beat_timeout", 0, 1);
   endtask

   task automatic send_pkt(input bit port, input logic [31:0] base,
                           input int n);
      for (int i = 0; i < n; i++)
         send_beat(port, base + i, i == n - 1);
   endtask

   task automatic drain();
      for (int t = 0; t < 100; t++) begin
         @(negedge clk);
         #3;
         if (sb.size() == 0)
            break;
      end
      chk("drain", sb.size(), 0);
   endtask

   task automatic do_reset(input int n);
      rst_n = 1'b0;
      s01.tvalid = 1'b0;
      s02.tvalid = 1'b0;
      m01.tready = 1'b1;
      repeat (n) @(negedge clk);
      rst_n = 1'b1;
      sb.delete();
      src_log.delete();
   endtask

   initial begin
      logic pat [6];
      logic order [6];
      pat   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      order = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

      // Reset with every input active
      rst_n = 1'b0;
      drive(1'b0, 32'h0000_00E1, 1'b0);
      drive(1'b1, 32'h0000_00E2, 1'b0);
      m01.tready = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_tvalid", m01.tvalid, 0);
      chk("rst_tdata", m01.tdata, 0);
      chk("rst_tstrb", m01.tstrb, 0);
      chk("rst_tlast", m01.tlast, 0);
      chk("rst_tid", m_tid, 0);
      chk("rst_rdy01", s01.tready, 0);
      chk("rst_rdy02", s02.tready, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      chk("first_grant01", s01.tready, 1);
      chk("first_grant02", s02.tready, 0);
      s01.tvalid = 1'b0;
      s02.tvalid = 1'b0;
      @(negedge clk);
      do_reset(2);

      // s01 only, 4-beat packet
      send_pkt(1'b0, 32'h11, 4);
      s01.tvalid = 1'b0;
      drain();
      chk("t2_pkts", src_log.size(), 1);

      // Back-to-back contention from both ports
      do_reset(2);
      fork
         begin
            for (int p = 0; p < 3; p++)
               send_pkt(1'b0, 32'hA0, 2);
            s01.tvalid = 1'b0;
         end
         begin
            for (int p = 0; p < 3; p++)
               send_pkt(1'b1, 32'hB0, 2);
            s02.tvalid = 1'b0;
         end
      join
      drain();
      chk("t3_pkts", src_log.size(), 6);
      for (int i = 0; i < 6 && i < src_log.size(); i++)
         chk($sformatf("order%0d", i), src_log[i], order[i]);

      // Downstream stalls during an s02 packet
      fork
         begin
            send_pkt(1'b1, 32'hC0, 3);
            s02.tvalid = 1'b0;
         end
         begin
            for (int i = 0; i < 6; i++) begin
               m01.tready = pat[i];
               @(negedge clk);
            end
            m01.tready = 1'b1;
         end
      join
      drain();

      // Reset in the middle of an s01 packet
      do_reset(2);
      send_beat(1'b0, 32'h51, 1'b0);
      send_beat(1'b0, 32'h52, 1'b0);
      drive(1'b0, 32'h53, 1'b0);
      rst_n = 1'b0;
      @(negedge clk);
      #3;
      chk("mid_rst_valid", m01.tvalid, 0);
      chk("mid_rst_sb", sb.size(), 0);
      chk("mid_rst_rdy", s01.tready, 0);
      s01.tvalid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send_pkt(1'b0, 32'h61, 2);
      s01.tvalid = 1'b0;
      drain();

`ifdef AXIS_ARB_PKT_COUNT_EN
      do_reset(2);
      fork
         begin
            for (int p = 0; p < 5; p++)
               send_pkt(1'b0, 32'h70 + p * 4, 2);
            s01.tvalid = 1'b0;
         end
         begin
            for (int p = 0; p < 2; p++)
               send_pkt(1'b1, 32'h90 + p * 4, 2);
            s02.tvalid = 1'b0;
         end
      join
      drain();
      chk("cnt_s01", cnt1, 5);
      chk("cnt_s02", cnt2, 2);
      force dut.cnt_s01_q = 16'hFFFF;
      @(negedge clk);
      release dut.cnt_s01_q;
      send_pkt(1'b0, 32'h80, 1);
      s01.tvalid = 1'b0;
      drain();
      chk("cnt_wrap", cnt1, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

endmodule
